dir_manager: RTL and testbench
==============================

DIR_MANAGER -- requirements
Module: dir_manager

Interface
REQ-001 Parameters SHALL be: TARGET_NIL, 3'd0, no port; TARGET_ACC, 3'd1, accumulator (non-port); TARGET_UP, 3'd2; TARGET_DOWN, 3'd3; TARGET_LEFT, 3'd4; TARGET_RIGHT, 3'd5; TARGET_ANY, 3'd6; TARGET_LAST, 3'd7.
REQ-002 Port order (positional) SHALL be: clk, reset, src, dst, then left/right/up/down in_data, in_valid, in_ready triples, then left/right/up/down out_data, out_valid, out_ready triples, then clk_en, dir_src_data, dir_dst_data.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 src  input  3  source target code of current instruction.
REQ-006 dst  input  3  destination target code of current instruction.
REQ-007 {left,right,up,down}_in_data  input  11 signed  neighbour data toward this node.
REQ-008 {left,right,up,down}_in_valid  input  1  neighbour offers in_data.
REQ-009 {left,right,up,down}_in_ready  output  1  this node consumes in_data.
REQ-010 {left,right,up,down}_out_data  output  11 signed  data offered to neighbour.
REQ-011 {left,right,up,down}_out_valid  output  1  out_data offered.
REQ-012 {left,right,up,down}_out_ready  input  1  neighbour accepts out_data.
REQ-013 clk_en  output  1  instruction may complete this cycle.
REQ-014 dir_src_data  output  11 signed  value read from selected source port.
REQ-015 dir_dst_data  input  11 signed  value to write to destination port.

Function
REQ-016 All handshake outputs and dir_src_data SHALL be combinational from src, dst, valids, readies, data and the LAST register.
REQ-017 Resolved source: UP/DOWN/LEFT/RIGHT select that port; ANY selects first valid input in priority LEFT, RIGHT, UP, DOWN (none if no valid); LAST selects stored last port (none if empty); NIL/ACC select no port.
REQ-018 src_ok SHALL be 1 when src is NIL or ACC, else 1 only if a resolved source port exists with in_valid=1.
REQ-019 Resolved destination: explicit direction selects that port; ANY offers on all four ports and resolves to first out_ready port in priority LEFT, RIGHT, UP, DOWN; LAST uses stored port (none if empty); NIL/ACC select none.
REQ-020 dst_ok SHALL be 1 when dst is NIL or ACC, else 1 only if the resolved destination port has out_ready=1; dst LAST with empty register SHALL give dst_ok=1 (write discarded, NIL behaviour); src LAST empty gives src_ok=1, dir_src_data=0.
REQ-021 clk_en SHALL equal src_ok AND dst_ok.
REQ-022 in_ready of the resolved source port SHALL equal dst_ok; all other in_ready SHALL be 0.
REQ-023 out_valid SHALL be src_ok on the explicit/LAST destination port, or on all four ports for dst ANY; all other out_valid SHALL be 0.
REQ-024 out_data SHALL equal dir_dst_data on ports with out_valid=1, else 0.
REQ-025 dir_src_data SHALL equal resolved source port in_data, else 0.
REQ-026 Same port as src and dst SHALL use independent in/out channels.
REQ-027 LAST register (none or one of four ports) SHALL update at rising clk when clk_en=1: from destination resolution if dst=ANY, else from source resolution if src=ANY; otherwise hold.

Reset
REQ-028 When reset=0 at rising clk, LAST register SHALL become none; combinational outputs follow REQ-016..025 throughout.
REQ-029 Reset asserted mid-transfer SHALL not alter combinational handshake outputs, only LAST state.

Verification
REQ-030 in_data L=1,R=2,U=3,D=4; src=LEFT, dst=NIL, left_in_valid=1 -> left_in_ready=1, dir_src_data=1, clk_en=1, all out_valid=0.
REQ-031 src=UP, dst=NIL, up_in_valid=0 -> clk_en=0, up_in_ready=1, dir_src_data=3.
REQ-032 src=DOWN, dst=RIGHT, down_in_valid=1, right_out_ready=0 -> right_out_valid=1, right_out_data=4, down_in_ready=0, clk_en=0; set right_out_ready=1 -> down_in_ready=1, clk_en=1.
REQ-033 src=ANY, dst=ACC, right/up valid=1 -> right_in_ready=1, dir_src_data=2, clk_en=1; next cycle src=LAST, up only valid -> clk_en=0.
REQ-034 src=NIL (dir_dst_data=999), dst=ANY, down_out_ready=1 only -> all out_valid=1, out_data=999, clk_en=1; then dst=LAST -> only down_out_valid=1.
REQ-035 reset=0 one edge then src=LAST, dst=NIL -> clk_en=1, dir_src_data=0, all in_ready=0.

Source files
------------

// File: rtl/dir_manager.sv
// Directional port manager for a mesh node.
// Resolves the source and destination target codes of the current instruction
// to the four neighbour channels, drives the valid/ready handshakes and
// remembers the last port used by an ANY transfer.
module dir_manager #(
  parameter logic [2:0] TARGET_NIL   = 3'd0,
  parameter logic [2:0] TARGET_ACC   = 3'd1,
  parameter logic [2:0] TARGET_UP    = 3'd2,
  parameter logic [2:0] TARGET_DOWN  = 3'd3,
  parameter logic [2:0] TARGET_LEFT  = 3'd4,
  parameter logic [2:0] TARGET_RIGHT = 3'd5,
  parameter logic [2:0] TARGET_ANY   = 3'd6,
  parameter logic [2:0] TARGET_LAST  = 3'd7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         src,
  input  logic [2:0]         dst,
  input  logic signed [10:0] left_in_data,
  input  logic               left_in_valid,
  output logic               left_in_ready,
  input  logic signed [10:0] right_in_data,
  input  logic               right_in_valid,
  output logic               right_in_ready,
  input  logic signed [10:0] up_in_data,
  input  logic               up_in_valid,
  output logic               up_in_ready,
  input  logic signed [10:0] down_in_data,
  input  logic               down_in_valid,
  output logic               down_in_ready,
  output logic signed [10:0] left_out_data,
  output logic               left_out_valid,
  input  logic               left_out_ready,
  output logic signed [10:0] right_out_data,
  output logic               right_out_valid,
  input  logic               right_out_ready,
  output logic signed [10:0] up_out_data,
  output logic               up_out_valid,
  input  logic               up_out_ready,
  output logic signed [10:0] down_out_data,
  output logic               down_out_valid,
  input  logic               down_out_ready,
  output logic               clk_en,
  output logic signed [10:0] dir_src_data,
  input  logic signed [10:0] dir_dst_data
);

  // Internal port index: 0 left, 1 right, 2 up, 3 down (also ANY priority order).
  localparam logic [1:0] PortLeft  = 2'd0;
  localparam logic [1:0] PortRight = 2'd1;
  localparam logic [1:0] PortUp    = 2'd2;
  localparam logic [1:0] PortDown  = 2'd3;

  logic signed [10:0] in_data [4];
  logic signed [10:0] out_data [4];
  logic [3:0] in_valid, out_ready, in_ready, out_valid;

  logic       src_hit, dst_hit, src_ok, dst_ok;
  logic [1:0] src_port, dst_port;
  logic       last_vld_q;
  logic [1:0] last_port_q;

  assign in_data[0] = left_in_data;
  assign in_data[1] = right_in_data;
  assign in_data[2] = up_in_data;
  assign in_data[3] = down_in_data;
  assign in_valid   = {down_in_valid, up_in_valid, right_in_valid, left_in_valid};
  assign out_ready  = {down_out_ready, up_out_ready, right_out_ready, left_out_ready};

  assign left_in_ready   = in_ready[0];
  assign right_in_ready  = in_ready[1];
  assign up_in_ready     = in_ready[2];
  assign down_in_ready   = in_ready[3];
  assign left_out_valid  = out_valid[0];
  assign right_out_valid = out_valid[1];
  assign up_out_valid    = out_valid[2];
  assign down_out_valid  = out_valid[3];
  assign left_out_data   = out_data[0];
  assign right_out_data  = out_data[1];
  assign up_out_data     = out_data[2];
  assign down_out_data   = out_data[3];

  // Resolve the source code to a port (ANY picks the first valid input).
  always_comb begin
    src_hit  = 1'b0;
    src_port = PortLeft;
    case (src)
      TARGET_NIL, TARGET_ACC: ;
      TARGET_LEFT:  begin src_hit = 1'b1; src_port = PortLeft;  end
      TARGET_RIGHT: begin src_hit = 1'b1; src_port = PortRight; end
      TARGET_UP:    begin src_hit = 1'b1; src_port = PortUp;    end
      TARGET_DOWN:  begin src_hit = 1'b1; src_port = PortDown;  end
      TARGET_ANY: begin
        src_hit = |in_valid;
        if (in_valid[0])      src_port = PortLeft;
        else if (in_valid[1]) src_port = PortRight;
        else if (in_valid[2]) src_port = PortUp;
        else                  src_port = PortDown;
      end
      TARGET_LAST:  begin src_hit = last_vld_q; src_port = last_port_q; end
      default: ;
    endcase
  end

  // Resolve the destination code to a port (ANY picks the first ready output).
  always_comb begin
    dst_hit  = 1'b0;
    dst_port = PortLeft;
    case (dst)
      TARGET_NIL, TARGET_ACC: ;
      TARGET_LEFT:  begin dst_hit = 1'b1; dst_port = PortLeft;  end
      TARGET_RIGHT: begin dst_hit = 1'b1; dst_port = PortRight; end
      TARGET_UP:    begin dst_hit = 1'b1; dst_port = PortUp;    end
      TARGET_DOWN:  begin dst_hit = 1'b1; dst_port = PortDown;  end
      TARGET_ANY: begin
        dst_hit = |out_ready;
        if (out_ready[0])      dst_port = PortLeft;
        else if (out_ready[1]) dst_port = PortRight;
        else if (out_ready[2]) dst_port = PortUp;
        else                   dst_port = PortDown;
      end
      TARGET_LAST:  begin dst_hit = last_vld_q; dst_port = last_port_q; end
      default: ;
    endcase
  end

  // Handshakes; an unresolved non-ANY target (NIL, ACC, empty LAST) never stalls.
  always_comb begin
    src_ok       = src_hit ? in_valid[src_port]  : (src != TARGET_ANY);
    dst_ok       = dst_hit ? out_ready[dst_port] : (dst != TARGET_ANY);
    clk_en       = src_ok & dst_ok;
    dir_src_data = src_hit ? in_data[src_port] : 11'sd0;
    for (int i = 0; i < 4; i++) begin
      in_ready[i]  = src_hit && (src_port == 2'(i)) && dst_ok;
      out_valid[i] = (dst == TARGET_ANY) ? src_ok
                                         : (dst_hit && (dst_port == 2'(i)) && src_ok);
      out_data[i]  = out_valid[i] ? dir_dst_data : 11'sd0;
    end
  end

  // LAST register: destination resolution of ANY wins over source resolution.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_vld_q  <= 1'b0;
      last_port_q <= PortLeft;
    end else if (clk_en) begin
      if (dst == TARGET_ANY) begin
        last_vld_q  <= dst_hit;
        last_port_q <= dst_port;
      end else if (src == TARGET_ANY) begin
        last_vld_q  <= src_hit;
        last_port_q <= src_port;
      end
    end
  end

endmodule

// File: tb/tb_dir_manager.sv
// Scoreboard bench for dir_manager: stimulus pushes expected responses,
// a monitor on the falling edge pops and compares them.
module tb_dir_manager;

  localparam logic [2:0] NIL = 3'd0, ACC = 3'd1, UP = 3'd2, DOWN = 3'd3;
  localparam logic [2:0] LEFT = 3'd4, RIGHT = 3'd5, ANY = 3'd6, LAST = 3'd7;

  logic clk = 1'b0;
  logic reset;
  logic [2:0] src, dst;
  logic [3:0] iv, orr;  // bit order {down, up, right, left}
  logic signed [10:0] dd;
  logic signed [10:0] l_od, r_od, u_od, d_od, src_data;
  logic l_ir, r_ir, u_ir, d_ir, l_ov, r_ov, u_ov, d_ov, clk_en;

  typedef struct {
    int                 id;
    logic               ce;
    logic [3:0]         ir;
    logic [3:0]         ov;
    logic signed [10:0] sd;
    logic signed [10:0] dd;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dir_manager dut (
    .clk(clk), .reset(reset), .src(src), .dst(dst),
    .left_in_data(11'sd1),  .left_in_valid(iv[0]),  .left_in_ready(l_ir),
    .right_in_data(11'sd2), .right_in_valid(iv[1]), .right_in_ready(r_ir),
    .up_in_data(11'sd3),    .up_in_valid(iv[2]),    .up_in_ready(u_ir),
    .down_in_data(11'sd4),  .down_in_valid(iv[3]),  .down_in_ready(d_ir),
    .left_out_data(l_od),  .left_out_valid(l_ov),  .left_out_ready(orr[0]),
    .right_out_data(r_od), .right_out_valid(r_ov), .right_out_ready(orr[1]),
    .up_out_data(u_od),    .up_out_valid(u_ov),    .up_out_ready(orr[2]),
    .down_out_data(d_od),  .down_out_valid(d_ov),  .down_out_ready(orr[3]),
    .clk_en(clk_en), .dir_src_data(src_data), .dir_dst_data(dd)
  );

  // Drive one vector after a rising edge and record the expected response.
  task automatic apply(input int id, input logic rst, input logic [2:0] s, input logic [2:0] d,
                       input logic [3:0] v, input logic [3:0] r, input logic signed [10:0] w,
                       input logic ce, input logic [3:0] ir, input logic [3:0] ov,
                       input logic signed [10:0] sd);
    exp_t e;
    @(posedge clk);
    #2;
    reset = rst; src = s; dst = d; iv = v; orr = r; dd = w;
    e.id = id; e.ce = ce; e.ir = ir; e.ov = ov; e.sd = sd; e.dd = w;
    sb.push_back(e);
  endtask

  // Monitor: compare every pending expectation against the settled outputs.
  always @(negedge clk) begin
    logic signed [10:0] od [4];
    logic signed [10:0] want;
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      od[0] = l_od; od[1] = r_od; od[2] = u_od; od[3] = d_od;
      checks++;
      if (clk_en === e.ce) passed++;
      else $display("FAIL vec%0d clk_en got %b want %b", e.id, clk_en, e.ce);
      checks++;
      if ({d_ir, u_ir, r_ir, l_ir} === e.ir) passed++;
      else $display("FAIL vec%0d in_ready got %b want %b", e.id, {d_ir, u_ir, r_ir, l_ir}, e.ir);
      checks++;
      if ({d_ov, u_ov, r_ov, l_ov} === e.ov) passed++;
      else $display("FAIL vec%0d out_valid got %b want %b", e.id, {d_ov, u_ov, r_ov, l_ov}, e.ov);
      checks++;
      if (src_data === e.sd) passed++;
      else $display("FAIL vec%0d dir_src_data got %0d want %0d", e.id, src_data, e.sd);
      for (int i = 0; i < 4; i++) begin
        want = e.ov[i] ? e.dd : 11'sd0;
        checks++;
        if (od[i] === want) passed++;
        else $display("FAIL vec%0d out_data[%0d] got %0d want %0d", e.id, i, od[i], want);
      end
    end
  end

  initial begin
    reset = 1'b0; src = NIL; dst = NIL; iv = 4'b0000; orr = 4'b0000; dd = 11'sd0;
    repeat (2) @(posedge clk);
    // Reset state: LAST empty behaves as NIL.
    apply(0,  1'b0, LAST, NIL,  4'b0000, 4'b0000, 11'sd0,   1'b1, 4'b0000, 4'b0000, 11'sd0);
    apply(1,  1'b1, LEFT, NIL,  4'b0001, 4'b0000, 11'sd0,   1'b1, 4'b0001, 4'b0000, 11'sd1);
    apply(2,  1'b1, UP,   NIL,  4'b0000, 4'b0000, 11'sd0,   1'b0, 4'b0100, 4'b0000, 11'sd3);
    apply(3,  1'b1, DOWN, RIGHT, 4'b1000, 4'b0000, 11'sd4,  1'b0, 4'b0000, 4'b0010, 11'sd4);
    apply(4,  1'b1, DOWN, RIGHT, 4'b1000, 4'b0010, 11'sd4,  1'b1, 4'b1000, 4'b0010, 11'sd4);
    // ANY source picks RIGHT over UP; LAST then remembers RIGHT.
    apply(5,  1'b1, ANY,  ACC,  4'b0110, 4'b0000, 11'sd0,   1'b1, 4'b0010, 4'b0000, 11'sd2);
    apply(6,  1'b1, LAST, ACC,  4'b0100, 4'b0000, 11'sd0,   1'b0, 4'b0010, 4'b0000, 11'sd2);
    // ANY destination broadcasts; LAST then remembers DOWN.
    apply(7,  1'b1, NIL,  ANY,  4'b0000, 4'b1000, 11'sd999, 1'b1, 4'b0000, 4'b1111, 11'sd0);
    apply(8,  1'b1, NIL,  LAST, 4'b0000, 4'b1000, 11'sd999, 1'b1, 4'b0000, 4'b1000, 11'sd0);
    apply(9,  1'b1, NIL,  LAST, 4'b0000, 4'b0000, 11'sd999, 1'b0, 4'b0000, 4'b1000, 11'sd0);
    apply(10, 1'b1, ANY,  NIL,  4'b0000, 4'b0000, 11'sd0,   1'b0, 4'b0000, 4'b0000, 11'sd0);
    // Both ANY: destination (LEFT) is what LAST records.
    apply(11, 1'b1, ANY,  ANY,  4'b1100, 4'b0101, -11'sd5,  1'b1, 4'b0100, 4'b1111, 11'sd3);
    apply(12, 1'b1, LAST, LAST, 4'b0001, 4'b0001, 11'sd7,   1'b1, 4'b0001, 4'b0001, 11'sd1);
    apply(13, 1'b1, NIL,  ANY,  4'b0000, 4'b0000, 11'sd7,   1'b0, 4'b0000, 4'b1111, 11'sd0);
    // Reset mid-transfer: outputs unchanged this cycle, LAST cleared after the edge.
    apply(14, 1'b0, LAST, LAST, 4'b0001, 4'b0001, 11'sd7,   1'b1, 4'b0001, 4'b0001, 11'sd1);
    apply(15, 1'b1, LAST, LAST, 4'b1111, 4'b1111, 11'sd9,   1'b1, 4'b0000, 4'b0000, 11'sd0);
    for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain pending %0d want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
